execute_muldiv_ctrl: RTL and testbench

- Sequences an iterative multiply/divide unit beside the Execute stage ALU.
- Owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests qualified by funct, as decoded for R-type in Execute.
- Raises stall toward the pipeline while a multi-cycle operation blocks a dependent request.

---
 rtl/execute_muldiv_ctrl_if.sv | 33 +++
 rtl/execute_muldiv_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_execute_muldiv_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_muldiv_ctrl_if.sv
// Request/response bundle between the Execute stage and the mul/div controller.
// Latency: none (wires only).
// Backpressure: stall tells the Execute side to hold start/funct/operands.
//
// Ports (signals):
//   start, funct, aluReadData1, aluReadData2 : Execute -> unit request
//   stall, busy, done, hi, lo, mfResult      : unit -> Execute status/results
interface execute_muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [5:0]        funct;
  logic [DATA_W-1:0] aluReadData1;
  logic [DATA_W-1:0] aluReadData2;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] mfResult;

  // Execute stage side
  modport master (
    output start, funct, aluReadData1, aluReadData2,
    input  stall, busy, done, hi, lo, mfResult
  );

  // Multiply/divide unit side
  modport slave (
    input  start, funct, aluReadData1, aluReadData2,
    output stall, busy, done, hi, lo, mfResult
  );
endinterface

// File: rtl/execute_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus MTHI/MTLO/MFHI/MFLO.
// Latency: op accepted cycle 0, CALC cycles 1..DATA_W, FIX cycle DATA_W+1, done/HI/LO in DATA_W+2.
// Backpressure: stall is raised for any recognised funct while busy; requester holds the request.
//
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : execute_muldiv_ctrl_if.slave (request in; stall/busy/done/hi/lo/mfResult out)
module execute_muldiv_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  execute_muldiv_ctrl_if.slave bus
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                op_div_q, op_div_d;   // 1: divide, 0: multiply
  logic                neg_res_q, neg_res_d; // operand signs differ (product / quotient)
  logic                neg_rem_q, neg_rem_d; // signed dividend was negative
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opb_q, opb_d;         // multiplicand / divisor magnitude

  // Request decode
  logic is_muldiv, is_mt, is_mf, is_known, is_signed;
  assign is_muldiv = (bus.funct == F_MULT) || (bus.funct == F_MULTU) ||
                     (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
  assign is_mt     = (bus.funct == F_MTHI) || (bus.funct == F_MTLO);
  assign is_mf     = (bus.funct == F_MFHI) || (bus.funct == F_MFLO);
  assign is_known  = is_muldiv || is_mt || is_mf;
  assign is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);

  // Operand magnitudes; unsigned ops pass raw values through.
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] mag_a, mag_b;
  assign a_neg = is_signed && bus.aluReadData1[DATA_W-1];
  assign b_neg = is_signed && bus.aluReadData2[DATA_W-1];
  assign mag_a = a_neg ? (-bus.aluReadData1) : bus.aluReadData1;
  assign mag_b = b_neg ? (-bus.aluReadData2) : bus.aluReadData2;

  // One shift-add step: add multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  logic [DATA_W:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                   (acc_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor; keep the difference if non-negative.
  // The remainder is always < divisor, so DATA_W+1 bits hold the shifted value.
  logic [DATA_W:0] div_sh;
  logic [DATA_W:0] div_diff;
  logic            div_ge;
  assign div_sh   = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_ge   = ~div_diff[DATA_W];

  // Sign fix-up applied in FIX
  logic [2*DATA_W-1:0] prod_fixed;
  logic [DATA_W-1:0]   quot_fixed, rem_fixed;
  assign prod_fixed = neg_res_q ? (-acc_q) : acc_q;
  assign quot_fixed = neg_res_q ? (-acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];
  assign rem_fixed  = neg_rem_q ? (-acc_q[2*DATA_W-1:DATA_W]) : acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    op_div_d  = op_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    opb_d     = opb_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_muldiv) begin
            // Both algorithms start from {0, |rs|} and consume |rt|.
            op_div_d  = (bus.funct == F_DIV) || (bus.funct == F_DIVU);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            acc_d     = {{DATA_W{1'b0}}, mag_a};
            opb_d     = mag_b;
            cnt_d     = '0;
            state_d   = S_CALC;
          end else if (bus.funct == F_MTHI) begin
            hi_d = bus.aluReadData1;
          end else if (bus.funct == F_MTLO) begin
            lo_d = bus.aluReadData1;
          end
        end
      end

      S_CALC: begin
        if (op_div_q) begin
          acc_d = {(div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0]),
                   acc_q[DATA_W-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (op_div_q) begin
          hi_d = rem_fixed;
          lo_d = quot_fixed;
        end else begin
          hi_d = prod_fixed[2*DATA_W-1:DATA_W];
          lo_d = prod_fixed[DATA_W-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      op_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      op_div_q  <= op_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
    end
  end

  logic busy_w;
  assign busy_w = (state_q != S_IDLE);

  assign bus.busy  = busy_w;
  assign bus.stall = bus.start && busy_w && is_known;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Register reads are only driven while a request is presented.
  always_comb begin
    bus.mfResult = '0;
    if (bus.start && is_mf) begin
      bus.mfResult = (bus.funct == F_MFHI) ? hi_q : lo_q;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Directed bench for execute_muldiv_ctrl: reset, mult/div results, stall, MT/MF, back-to-back.
// Latency: checks done at cycle 34 after acceptance at cycle 0.
// Backpressure: requester holds start/funct/operands while stall is high.
module tb_execute_muldiv_ctrl;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  execute_muldiv_ctrl_if #(.DATA_W(32)) bus ();

  execute_muldiv_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one mul/div op at cycle 0 and observe it for 40 cycles.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic stall0, output int busy_cnt, output int done_at,
                        output int done_cnt, output logic [31:0] hi_v, output logic [31:0] lo_v);
    bus.start = 1'b1;
    bus.funct = f;
    bus.aluReadData1 = a;
    bus.aluReadData2 = b;
    #1;
    stall0 = bus.stall;
    step();
    bus.start = 1'b0;
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    hi_v = '0;
    lo_v = '0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == 34) begin
        hi_v = bus.hi;
        lo_v = bus.lo;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.funct = '0;
    bus.aluReadData1 = '0;
    bus.aluReadData2 = '0;
    repeat (2) step();
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_init hi=%h lo=%h busy=%b done=%b stall=%b required 0", bus.hi, bus.lo, bus.busy, bus.done, bus.stall);
    end
    rst_n = 1'b1;
    step();
    // Load HI, then abandon a MULTU mid-CALC with reset.
    bus.start = 1'b1;
    bus.funct = F_MTHI;
    bus.aluReadData1 = 32'h0000_0055;
    step();
    bus.funct = F_MULTU;
    bus.aluReadData1 = 32'h0000_1234;
    bus.aluReadData2 = 32'h0000_0010;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    checks++;
    if (bus.busy !== 1'b1 || bus.hi !== 32'h55) begin
      failures++;
      $display("FAIL reset_precond busy=%b hi=%h required busy=1 hi=00000055", bus.busy, bus.hi);
    end
    bus.start = 1'b1;
    bus.funct = F_MULT;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_midcalc hi=%h lo=%h busy=%b done=%b stall=%b required 0", bus.hi, bus.lo, bus.busy, bus.done, bus.stall);
    end
    bus.start = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    logic stall0;
    int busy_cnt, done_at, done_cnt;
    logic [31:0] h, l;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'h2, stall0, busy_cnt, done_at, done_cnt, h, l);
    checks++;
    if (stall0 !== 1'b0 || busy_cnt != 33 || done_at != 34 || done_cnt != 1) begin
      failures++;
      $display("FAIL multu_timing stall0=%b busy=%0d done_at=%0d pulses=%0d required 0/33/34/1", stall0, busy_cnt, done_at, done_cnt);
    end
    checks++;
    if (h !== 32'h0000_0001 || l !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL multu_result hi=%h lo=%h required 00000001 fffffffe", h, l);
    end
    run_op(F_MULT, 32'hFFFF_FFFD, 32'h7, stall0, busy_cnt, done_at, done_cnt, h, l);
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB || done_at != 34) begin
      failures++;
      $display("FAIL mult_signed hi=%h lo=%h done_at=%0d required ffffffff ffffffeb 34", h, l, done_at);
    end
  endtask

  task automatic test_div();
    logic stall0;
    int busy_cnt, done_at, done_cnt;
    logic [31:0] h, l;
    run_op(F_DIV, 32'hFFFF_FFF9, 32'h2, stall0, busy_cnt, done_at, done_cnt, h, l);
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD || busy_cnt != 33 || done_at != 34) begin
      failures++;
      $display("FAIL div_signed hi=%h lo=%h busy=%0d done_at=%0d required ffffffff fffffffd 33 34", h, l, busy_cnt, done_at);
    end
    run_op(F_DIVU, 32'h7, 32'h0, stall0, busy_cnt, done_at, done_cnt, h, l);
    checks++;
    if (h !== 32'h0000_0007 || l !== 32'hFFFF_FFFF || done_at != 34) begin
      failures++;
      $display("FAIL divu_by_zero hi=%h lo=%h done_at=%0d required 00000007 ffffffff 34", h, l, done_at);
    end
    run_op(F_DIV, 32'h5, 32'h0, stall0, busy_cnt, done_at, done_cnt, h, l);
    checks++;
    if (h !== 32'h0000_0005 || l !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_pos_by_zero hi=%h lo=%h required 00000005 ffffffff", h, l);
    end
    run_op(F_DIV, 32'hFFFF_FFF9, 32'h0, stall0, busy_cnt, done_at, done_cnt, h, l);
    checks++;
    if (h !== 32'hFFFF_FFF9 || l !== 32'h0000_0001) begin
      failures++;
      $display("FAIL div_neg_by_zero hi=%h lo=%h required fffffff9 00000001", h, l);
    end
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, stall0, busy_cnt, done_at, done_cnt, h, l);
    checks++;
    if (h !== 32'h0000_0000 || l !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_overflow hi=%h lo=%h required 00000000 80000000", h, l);
    end
  endtask

  task automatic test_stall();
    int stall_cnt;
    bus.start = 1'b1;
    bus.funct = F_DIVU;
    bus.aluReadData1 = 32'd100;
    bus.aluReadData2 = 32'd7;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept stall=%b required 0", bus.stall);
    end
    step();
    bus.start = 1'b0;
    stall_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 2) begin
        bus.start = 1'b1;
        bus.funct = F_ADD;
      end
      if (c == 3) bus.start = 1'b0;
      if (c == 5) begin
        bus.start = 1'b1;
        bus.funct = F_MFLO;
      end
      #1;
      if (c == 2) begin
        checks++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL stall_nonmuldiv stall=%b busy=%b required 0 1", bus.stall, bus.busy);
        end
      end
      if (c >= 5 && bus.stall === 1'b1) stall_cnt++;
      step();
    end
    checks++;
    if (stall_cnt != 29) begin
      failures++;
      $display("FAIL stall_cycles count=%0d required 29", stall_cnt);
    end
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.mfResult !== 32'd14 || bus.hi !== 32'd2 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL stall_release stall=%b mf=%h hi=%h done=%b required 0 0000000e 00000002 1", bus.stall, bus.mfResult, bus.hi, bus.done);
    end
    step();
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_mt_mf();
    bus.start = 1'b1;
    bus.funct = F_MTHI;
    bus.aluReadData1 = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL mthi_stall stall=%b required 0", bus.stall);
    end
    step();
    checks++;
    if (bus.hi !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL mthi_write hi=%h required deadbeef", bus.hi);
    end
    bus.funct = F_MTLO;
    bus.aluReadData1 = 32'h1234_5678;
    step();
    checks++;
    if (bus.lo !== 32'h1234_5678 || bus.hi !== 32'hDEAD_BEEF || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo_write lo=%h hi=%h busy=%b required 12345678 deadbeef 0", bus.lo, bus.hi, bus.busy);
    end
    bus.funct = F_MFHI;
    #1;
    checks++;
    if (bus.mfResult !== 32'hDEAD_BEEF || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL mfhi_read mf=%h stall=%b required deadbeef 0", bus.mfResult, bus.stall);
    end
    bus.funct = F_MFLO;
    #1;
    checks++;
    if (bus.mfResult !== 32'h1234_5678) begin
      failures++;
      $display("FAIL mflo_read mf=%h required 12345678", bus.mfResult);
    end
    bus.start = 1'b0;
    bus.funct = F_MFHI;
    #1;
    checks++;
    if (bus.mfResult !== 32'h0) begin
      failures++;
      $display("FAIL mf_gated mf=%h required 00000000", bus.mfResult);
    end
    bus.funct = F_ADD;
    step();
  endtask

  task automatic test_back_to_back();
    int no_stall;
    int done_at;
    logic [31:0] h, l;
    bus.start = 1'b1;
    bus.funct = F_MULTU;
    bus.aluReadData1 = 32'd3;
    bus.aluReadData2 = 32'd5;
    step();
    // Next op presented immediately and held while stalled.
    bus.funct = F_DIVU;
    bus.aluReadData1 = 32'd100;
    bus.aluReadData2 = 32'd7;
    no_stall = 0;
    for (int c = 1; c <= 33; c++) begin
      #1;
      if (bus.stall !== 1'b1) no_stall++;
      step();
    end
    #1;
    checks++;
    if (no_stall != 0 || bus.stall !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd15 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first gaps=%0d stall=%b hi=%h lo=%h done=%b required 0 0 00000000 0000000f 1", no_stall, bus.stall, bus.hi, bus.lo, bus.done);
    end
    step();
    bus.start = 1'b0;
    done_at = -1;
    h = '0;
    l = '0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done && done_at < 0) done_at = c;
      if (c == 34) begin
        h = bus.hi;
        l = bus.lo;
      end
      step();
    end
    checks++;
    if (done_at != 34 || h !== 32'd2 || l !== 32'd14) begin
      failures++;
      $display("FAIL b2b_second done_at=%0d hi=%h lo=%h required 34 00000002 0000000e", done_at, h, l);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mt_mf();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
